// File: rtl/snake_pkg.sv
// Shared Snake-game types: grid defaults, coordinate widths, spawner state
// encoding and the off-grid test used when screening random food candidates.
package snake_pkg;

    localparam int unsigned GRID_W_DEF = 40;
    localparam int unsigned GRID_H_DEF = 30;
    localparam int unsigned COORD_X_W  = 6;
    localparam int unsigned COORD_Y_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        PROBE = 2'd2,
        WAIT  = 2'd3
    } spawn_state_t;

    function automatic logic off_grid(
        input logic [COORD_X_W-1:0] x,
        input logic [COORD_Y_W-1:0] y,
        input int unsigned          w = GRID_W_DEF,
        input int unsigned          h = GRID_H_DEF
    );
        return (32'(x) >= w) || (32'(y) >= h);
    endfunction

endpackage

// File: rtl/food_spawner.sv
// Turns the free-running LFSR value into a legal, unoccupied food cell,
// retrying on off-grid or snake-occupied candidates up to MAX_TRIES times.
module food_spawner
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W    = GRID_W_DEF,
    parameter int unsigned GRID_H    = GRID_H_DEF,
    parameter int unsigned MAX_TRIES = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [14:0]          rnd,
    input  logic                 spawn_req,
    output logic                 busy,
    output logic                 occ_rd,
    output logic [COORD_X_W-1:0] occ_x,
    output logic [COORD_Y_W-1:0] occ_y,
    input  logic                 occ_hit,
    output logic [COORD_X_W-1:0] food_x,
    output logic [COORD_Y_W-1:0] food_y,
    output logic                 food_valid,
    output logic                 fail
);

    localparam logic [7:0] MAX_T = 8'(MAX_TRIES);

    spawn_state_t         state_q, state_d;
    logic [14:0]          last_rnd_q, last_rnd_d;
    logic [COORD_X_W-1:0] cand_x_q, cand_x_d;
    logic [COORD_Y_W-1:0] cand_y_q, cand_y_d;
    logic [7:0]           tries_q, tries_d;
    logic                 busy_q, busy_d;
    logic                 occ_rd_q, occ_rd_d;
    logic [COORD_X_W-1:0] occ_x_q, occ_x_d;
    logic [COORD_Y_W-1:0] occ_y_q, occ_y_d;
    logic [COORD_X_W-1:0] food_x_q, food_x_d;
    logic [COORD_Y_W-1:0] food_y_q, food_y_d;
    logic                 food_valid_q, food_valid_d;
    logic                 fail_q, fail_d;
    logic                 reject;

    always_comb begin
        state_d      = state_q;
        last_rnd_d   = last_rnd_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        tries_d      = tries_q;
        occ_rd_d     = 1'b0;
        occ_x_d      = occ_x_q;
        occ_y_d      = occ_y_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        fail_d       = 1'b0;
        reject       = 1'b0;

        case (state_q)
            IDLE: begin
                if (spawn_req) begin
                    food_valid_d = 1'b0;
                    tries_d      = 8'd0;
                    state_d      = DRAW;
                end
            end
            DRAW: begin
                // An unchanged LFSR value is stale: wait for a fresh draw.
                if (rnd != last_rnd_q) begin
                    last_rnd_d = rnd;
                    cand_x_d   = rnd[5:0];
                    cand_y_d   = rnd[10:6];
                    if (off_grid(rnd[5:0], rnd[10:6], GRID_W, GRID_H)) begin
                        reject = 1'b1;
                    end else begin
                        state_d  = PROBE;
                        occ_rd_d = 1'b1;
                        occ_x_d  = rnd[5:0];
                        occ_y_d  = rnd[10:6];
                    end
                end
            end
            PROBE: state_d = WAIT;
            WAIT: begin
                if (occ_hit) begin
                    reject = 1'b1;
                end else begin
                    food_x_d     = cand_x_q;
                    food_y_d     = cand_y_q;
                    food_valid_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (reject) begin
            tries_d = tries_q + 8'd1;
            if (tries_d == MAX_T) begin
                fail_d  = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = DRAW;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_rnd_q   <= '0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            tries_q      <= '0;
            busy_q       <= 1'b0;
            occ_rd_q     <= 1'b0;
            occ_x_q      <= '0;
            occ_y_q      <= '0;
            food_x_q     <= '0;
            food_y_q     <= '0;
            food_valid_q <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_rnd_q   <= last_rnd_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            tries_q      <= tries_d;
            busy_q       <= busy_d;
            occ_rd_q     <= occ_rd_d;
            occ_x_q      <= occ_x_d;
            occ_y_q      <= occ_y_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            fail_q       <= fail_d;
        end
    end

    assign busy       = busy_q;
    assign occ_rd     = occ_rd_q;
    assign occ_x      = occ_x_q;
    assign occ_y      = occ_y_q;
    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign food_valid = food_valid_q;
    assign fail       = fail_q;

endmodule

// File: tb/tb_food_spawner.sv
// Directed bench for food_spawner: best case, off-grid and occupied rejects,
// exhaustion with MAX_TRIES = 3, stale LFSR values with busy-ignore, and reset.
module tb_food_spawner;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] rnd = '0;
    logic        spawn_req = 1'b0;
    logic        occ_hit = 1'b0;
    logic        busy, occ_rd, food_valid, fail;
    logic [5:0]  occ_x, food_x;
    logic [4:0]  occ_y, food_y;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int rd_cnt;

    food_spawner #(.GRID_W(40), .GRID_H(30), .MAX_TRIES(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .rnd        (rnd),
        .spawn_req  (spawn_req),
        .busy       (busy),
        .occ_rd     (occ_rd),
        .occ_x      (occ_x),
        .occ_y      (occ_y),
        .occ_hit    (occ_hit),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid),
        .fail       (fail)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("check %-22s got=%0h exp=%0h ok", tag, got, exp);
        end else begin
            $display("FAIL %-22s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        spawn_req = 1'b0;
        occ_hit = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic pulse_spawn();
        spawn_req = 1'b1;
        tick();
        spawn_req = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        check("rst_busy", 32'(busy), 0);
        check("rst_occ_rd", 32'(occ_rd), 0);
        check("rst_occ_xy", {occ_x, occ_y}, 0);
        check("rst_food", {food_valid, food_x, food_y}, 0);
        check("rst_fail", 32'(fail), 0);
        check("rst_state", 32'(dut.state_q), 0);

        // best case: rnd 0x0145 -> (5,5)
        rnd = 15'h0145;
        pulse_spawn();                                      // edge 1
        check("t1_e1_state", 32'(dut.state_q), 1);
        check("t1_e1_busy", 32'(busy), 1);
        check("t1_e1_occ_rd", 32'(occ_rd), 0);
        tick();                                             // edge 2
        check("t1_e2_occ_rd", 32'(occ_rd), 1);
        check("t1_e2_occ_xy", {occ_x, occ_y}, {6'd5, 5'd5});
        tick();                                             // edge 3
        check("t1_e3_occ_rd", 32'(occ_rd), 0);
        check("t1_e3_fv", 32'(food_valid), 0);
        tick();                                             // edge 4
        check("t1_e4_food", {food_valid, food_x, food_y}, {1'b1, 6'd5, 5'd5});
        check("t1_e4_busy", 32'(busy), 0);

        // off-grid reject: x = 63 for one cycle
        do_reset();
        rnd = 15'h003F;
        pulse_spawn();                                      // edge 1: DRAW
        tick();                                             // edge 2: reject
        check("t2_e2_no_rd", 32'(occ_rd), 0);
        check("t2_e2_state", 32'(dut.state_q), 1);
        rnd = 15'h0145;
        tick();                                             // edge 3: PROBE
        check("t2_e3_occ", {occ_rd, occ_x, occ_y}, {1'b1, 6'd5, 5'd5});
        tick();                                             // edge 4: WAIT
        check("t2_e4_fv", 32'(food_valid), 0);
        tick();                                             // edge 5
        check("t2_e5_food", {food_valid, food_x, food_y}, {1'b1, 6'd5, 5'd5});

        // occupied reject, then (2,2)
        do_reset();
        rnd = 15'h0145;
        occ_hit = 1'b1;
        pulse_spawn();
        tick();
        check("t3_rd1", {occ_rd, occ_x, occ_y}, {1'b1, 6'd5, 5'd5});
        tick();                                             // WAIT, hit sampled at next edge
        rnd = 15'h0082;
        tick();
        check("t3_rej_fv", 32'(food_valid), 0);
        check("t3_rej_state", 32'(dut.state_q), 1);
        occ_hit = 1'b0;
        tick();
        check("t3_rd2", {occ_rd, occ_x, occ_y}, {1'b1, 6'd2, 5'd2});
        tick();
        tick();
        check("t3_food", {food_valid, food_x, food_y}, {1'b1, 6'd2, 5'd2});

        // exhaustion after 3 off-grid rejections
        do_reset();
        rnd = 15'h003F;
        rd_cnt = 0;
        pulse_spawn();                                      // edge 1: DRAW
        tick();                                             // reject 1
        rd_cnt += int'(occ_rd);
        check("t4_r1_fail", 32'(fail), 0);
        rnd = 15'h003E;
        tick();                                             // reject 2
        rd_cnt += int'(occ_rd);
        check("t4_r2_busy", 32'(busy), 1);
        rnd = 15'h003F;
        tick();                                             // reject 3
        rd_cnt += int'(occ_rd);
        check("t4_r3_fail", 32'(fail), 1);
        check("t4_r3_busy", 32'(busy), 0);
        check("t4_r3_fv", 32'(food_valid), 0);
        check("t4_no_occ_rd", 32'(rd_cnt), 0);
        rnd = 15'h003E;
        tick();
        check("t4_fail_gone", 32'(fail), 0);
        check("t4_idle", 32'(dut.state_q), 0);

        // stale value and busy-ignore
        do_reset();
        rnd = 15'h0145;
        pulse_spawn();
        repeat (3) tick();
        check("t5_first_food", {food_valid, food_x, food_y}, {1'b1, 6'd5, 5'd5});
        pulse_spawn();                                      // rnd still equals last_rnd
        check("t5_fv_cleared", 32'(food_valid), 0);
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            spawn_req = (i == 3);
            tick();
            rd_cnt += int'(occ_rd);
        end
        spawn_req = 1'b0;
        check("t5_stuck_draw", 32'(dut.state_q), 1);
        check("t5_stuck_no_rd", 32'(rd_cnt), 0);
        rnd = 15'h0082;
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            rd_cnt += int'(occ_rd);
        end
        check("t5_one_probe", 32'(rd_cnt), 1);
        check("t5_food", {food_valid, food_x, food_y}, {1'b1, 6'd2, 5'd2});
        check("t5_idle", {busy, 2'(dut.state_q)}, 0);

        // reset asserted while in WAIT
        do_reset();
        rnd = 15'h0145;
        pulse_spawn();
        tick();
        tick();
        check("t6_in_wait", 32'(dut.state_q), 3);
        reset = 1'b1;
        #1;
        check("t6_rst_outs", {busy, occ_rd, occ_x, occ_y, food_valid, food_x, food_y, fail}, 0);
        check("t6_rst_state", 32'(dut.state_q), 0);
        tick();
        reset = 1'b0;
        rd_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            rd_cnt += int'(fail) + int'(occ_rd) + int'(food_valid);
        end
        check("t6_quiet_after", 32'(rd_cnt), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/food_spawner.md
# food_spawner

Controller that turns the free-running 15-bit LFSR value into a legal food position for the Snake game. On a spawn request it draws fresh random values and rejects any candidate that is off-grid or occupied by the snake, checking occupancy through a one-cycle-latency read port. It sits between the random-number generator, the snake occupancy map and the game-state FSM.

## Interface
- GRID_W, 40, playfield width in cells; must be ≤ 64
- GRID_H, 30, playfield height in cells; must be ≤ 32
- MAX_TRIES, 255, rejected draws allowed before reporting failure; range 1..255

- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- rnd  in  15  current LFSR output
- spawn_req  in  1  one-cycle request for a new food position
- busy  out  1  high in every state except IDLE
- occ_rd  out  1  occupancy read strobe, one cycle wide
- occ_x  out  6  occupancy read column
- occ_y  out  5  occupancy read row
- occ_hit  in  1  occupancy result, valid the cycle after occ_rd; 1 = cell holds snake
- food_x  out  6  accepted food column
- food_y  out  5  accepted food row
- food_valid  out  1  high while food_x/food_y hold an accepted position
- fail  out  1  one-cycle pulse when MAX_TRIES is exhausted

## Operation
- Candidate mapping: cand_x = rnd[5:0], cand_y = rnd[10:6]. rnd[14:11] is unused.
- A candidate is off-grid when cand_x ≥ GRID_W or cand_y ≥ GRID_H. The comparison is unsigned.
- Internal registers: last_rnd (15 bits), cand_x, cand_y, tries (8 bits).
- States:
  - IDLE. On spawn_req: clear food_valid, set tries = 0, go to DRAW.
  - DRAW. If rnd == last_rnd, stay in DRAW; a stale value is never reused.
    - Otherwise latch last_rnd = rnd and cand_x/cand_y from rnd.
    - If the candidate is off-grid, it is a rejection; go to PROBE otherwise.
  - PROBE. Drive occ_rd = 1, occ_x = cand_x, occ_y = cand_y. Go to WAIT.
  - WAIT. Sample occ_hit.
    - occ_hit = 1 is a rejection.
    - occ_hit = 0: food_x = cand_x, food_y = cand_y, food_valid = 1, go to IDLE.
- Rejection handling: tries = tries + 1.
  - If the new tries value equals MAX_TRIES: pulse fail, leave food_valid = 0, go to IDLE.
  - Otherwise go to (or stay in) DRAW.
- spawn_req is ignored while busy = 1; it is not queued.
- food_x, food_y and food_valid hold until the next accepted spawn_req or reset.
- occ_x/occ_y keep the last driven value outside PROBE. They are meaningful only when occ_rd = 1.

## Timing
- Reset values: state = IDLE. The outputs busy, occ_rd, occ_x, occ_y, food_x, food_y, food_valid and fail are all 0. last_rnd = 0 and tries = 0.
- Best-case latency, with spawn_req sampled at edge 0 and rnd already different from last_rnd:
  - edge 1: DRAW
  - edge 2: PROBE, with occ_rd high in cycle 2
  - edge 3: WAIT
  - edge 4: food_valid = 1
- Each extra cycle in which rnd equals last_rnd adds one cycle of latency.
- Each rejection in DRAW costs 1 cycle. Each occupied-cell rejection costs 3 cycles (DRAW, PROBE, WAIT).
- fail is asserted for exactly one cycle, registered on the same edge that returns the FSM to IDLE.
- busy drops on that same edge.
- A spawn_req arriving in the same cycle that busy falls is ignored. It is accepted from the next cycle on.
- Reset asserted mid-operation returns the block to IDLE immediately. No fail pulse, no occ_rd and no partial food update follow.

## Structure
- The shared package snake_pkg holds:
  - the GRID_W/GRID_H defaults
  - COORD_X_W = 6 and COORD_Y_W = 5
  - the state enum (IDLE, DRAW, PROBE, WAIT)
  - an off_grid(x, y) function
- No sub-module. The rng instance and the occupancy map stay external and are wired up in the top level.

## Test plan
- Accept first draw: last_rnd = 0, hold rnd = 15'h0145, occ_hit = 0, pulse spawn_req.
  - Required: occ_rd with (5,5) in cycle 2; food = (5,5) and food_valid = 1 at edge 4.
- Off-grid reject: rnd = 15'h003F (x = 63) for 1 cycle, then 15'h0145.
  - Required: no occ_rd for x = 63; food = (5,5) one cycle later than the best case.
- Occupied reject: occ_hit = 1 on the first probe of (5,5), then rnd = 15'h0082 with occ_hit = 0.
  - Required: a second occ_rd with (2,2); food = (2,2).
- Exhaustion: MAX_TRIES = 3, rnd alternating between off-grid values 15'h003F and 15'h003E.
  - Required: fail pulse for 1 cycle after the 3rd rejection; food_valid = 0; busy = 0.
- Stale value and busy-ignore: rnd held constant at last_rnd for 10 cycles, with a second spawn_req during that time.
  - Required: FSM stays in DRAW; the second request has no effect.
  - Then change rnd and require exactly one accepted result.
- Reset mid-operation: assert reset in WAIT.
  - Required: all outputs 0 and state IDLE on that edge; no fail pulse.
